// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control FSM.
// State encodings are exported so the core top and the bench decode state_dbg identically.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXECUTE = 3'd3,
      ST_MEM     = 3'd4,
      ST_HALT    = 3'd5
   } state_t;

   // Redirect the PC for jumps and for taken branches; everything else falls through.
   function automatic logic pc_target(input logic jal, input logic jalr,
                                      input logic branch, input logic take);
      return jal | jalr | (branch & take);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_retire_counter.sv
// Retired-instruction counter: enable-gated, wraps silently, asynchronous active-low clear.
module retire_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   output logic [CNT_WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the single-issue RV32I core: fetch/decode/execute/mem sequencing,
// shared memory port arbitration, retire counting and halt on SYSTEM or unrecognised opcode.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 dec_alureg,
   input  logic                 dec_aluimm,
   input  logic                 dec_branch,
   input  logic                 dec_jal,
   input  logic                 dec_jalr,
   input  logic                 dec_lui,
   input  logic                 dec_auipc,
   input  logic                 dec_load,
   input  logic                 dec_store,
   input  logic                 dec_system,
   input  logic                 dec_regwrite,
   input  logic                 take_branch,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 mem_addr_sel,
   output logic                 ir_we,
   output logic                 pc_we,
   output logic                 pc_sel_target,
   output logic                 reg_we,
   output logic                 halted,
   output logic                 illegal,
   output logic [CNT_WIDTH-1:0] instret,
   output logic [2:0]           state_dbg
);

   state_t state_q, state_d;
   logic   retire;
   logic   set_halt;
   logic   set_illegal;
   logic   any_class;

   assign any_class = |{dec_alureg, dec_aluimm, dec_branch, dec_jal, dec_jalr,
                        dec_lui, dec_auipc, dec_load, dec_store, dec_system};
   assign state_dbg = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         halted  <= 1'b0;
         illegal <= 1'b0;
      end else begin
         state_q <= state_d;
         if (set_halt)    halted  <= 1'b1;
         if (set_illegal) illegal <= 1'b1;
      end
   end

   always_comb begin
      state_d       = state_q;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr_sel  = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      pc_sel_target = 1'b0;
      reg_we        = 1'b0;
      retire        = 1'b0;
      set_halt      = 1'b0;
      set_illegal   = 1'b0;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: state_d = ST_EXECUTE;
         ST_EXECUTE: begin
            // Priority order also resolves decoder faults with several flags set.
            if (dec_system) begin
               set_halt = 1'b1;
               state_d  = ST_HALT;
            end else if (!any_class) begin
               set_halt    = 1'b1;
               set_illegal = 1'b1;
               state_d     = ST_HALT;
            end else if (dec_load || dec_store) begin
               state_d = ST_MEM;
            end else begin
               pc_we         = 1'b1;
               pc_sel_target = pc_target(dec_jal, dec_jalr, dec_branch, take_branch);
               reg_we        = dec_regwrite;
               retire        = 1'b1;
               state_d       = ST_FETCH;
            end
         end
         ST_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = dec_store;
            if (mem_ready) begin
               reg_we  = dec_load;
               pc_we   = 1'b1;
               retire  = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   retire_counter #(.CNT_WIDTH(CNT_WIDTH)) u_retire (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (retire),
      .count (instret)
   );

endmodule
